// File: rtl/huc_bus_pkg.sv
// Shared definitions for the HuC6280 memory bus slice.
//   HUC_ADDR_W / HUC_DATA_W : physical bus widths behind the CPU core.
//   arb_state_t             : ownership states of the memory arbiter.
package huc_bus_pkg;

    localparam int HUC_ADDR_W = 21;
    localparam int HUC_DATA_W = 8;

    // ARB_HOLD is bus-wise identical to ARB_CPU; it only marks that the
    // post-burst CPU slot is still running, so aux requests are ignored.
    typedef enum logic [1:0] {
        ARB_CPU   = 2'd0,
        ARB_AUX   = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_HOLD  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/huc_mem_arbiter.sv
// Shares the single HuC6280 physical memory bus between the CPU (default
// owner) and one auxiliary master. The aux master stalls the CPU via
// cpu_rdy_n and receives bounded bursts; after a burst-limit release the CPU
// keeps the bus for CPU_MIN_SLOT enabled cycles before aux may win again.
//
// Ports:
//   clk, reset_n (sync, active low), clk_en (FSM/counter advance enable)
//   cpu_addr/cpu_re/cpu_we/cpu_wdata -> CPU side; cpu_rdata, cpu_rdy_n back
//   aux_req/aux_addr/aux_we/aux_wdata -> aux side; aux_gnt, aux_rdata,
//     aux_rvalid back (rvalid one cycle after an accepted read)
//   mem_addr/mem_re/mem_we/mem_wdata -> memory; mem_rdata (1-cycle latency)
module huc_mem_arbiter
    import huc_bus_pkg::*;
#(
    parameter int AUX_MAX_BURST = 4,
    parameter int CPU_MIN_SLOT  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic [HUC_ADDR_W-1:0] cpu_addr,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [HUC_DATA_W-1:0] cpu_wdata,
    output logic [HUC_DATA_W-1:0] cpu_rdata,
    output logic                  cpu_rdy_n,
    input  logic                  aux_req,
    input  logic [HUC_ADDR_W-1:0] aux_addr,
    input  logic                  aux_we,
    input  logic [HUC_DATA_W-1:0] aux_wdata,
    output logic                  aux_gnt,
    output logic [HUC_DATA_W-1:0] aux_rdata,
    output logic                  aux_rvalid,
    output logic [HUC_ADDR_W-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [HUC_DATA_W-1:0] mem_wdata,
    input  logic [HUC_DATA_W-1:0] mem_rdata
);

    localparam int BW = $clog2(AUX_MAX_BURST + 1);
    localparam int HW = $clog2(CPU_MIN_SLOT + 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(AUX_MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(AUX_MAX_BURST - 1);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(CPU_MIN_SLOT);

    arb_state_t    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          rvalid_d;
    logic          bus_aux;

    // Read data is simply fanned out; only rvalid qualifies it for aux.
    assign cpu_rdata = mem_rdata;
    assign aux_rdata = mem_rdata;

    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        hold_d   = hold_q;
        aux_gnt  = 1'b0;
        rvalid_d = aux_rvalid;

        // DRAIN keeps the aux address on the bus but with strobes low.
        bus_aux   = (state_q == ARB_AUX) || (state_q == ARB_DRAIN);
        mem_addr  = bus_aux ? aux_addr  : cpu_addr;
        mem_wdata = bus_aux ? aux_wdata : cpu_wdata;
        mem_re    = bus_aux ? 1'b0 : cpu_re;
        mem_we    = bus_aux ? 1'b0 : cpu_we;

        case (state_q)
            ARB_CPU: begin
                if (clk_en && aux_req) state_d = ARB_AUX;
            end
            ARB_HOLD: begin
                if (clk_en) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q <= HW'(1)) state_d = ARB_CPU;
                end
            end
            ARB_AUX: begin
                aux_gnt = clk_en & aux_req;
                mem_re  = aux_gnt & ~aux_we;
                mem_we  = aux_gnt &  aux_we;
                if (aux_gnt) begin
                    burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
                    // Limit hit wins over a simultaneous request drop.
                    if (burst_q >= BURST_LAST) begin
                        state_d = ARB_DRAIN;
                        hold_d  = HOLD_INIT;
                    end
                end else if (clk_en && !aux_req) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (clk_en) begin
                    burst_d = '0;
                    state_d = (hold_q != '0) ? ARB_HOLD : ARB_CPU;
                end
            end
            default: state_d = ARB_CPU;
        endcase

        if (clk_en) rvalid_d = aux_gnt & ~aux_we;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ARB_CPU;
            burst_q    <= '0;
            hold_q     <= '0;
            cpu_rdy_n  <= 1'b0;
            aux_rvalid <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            hold_q     <= hold_d;
            // state_d equals state_q when clk_en=0, so this holds too.
            cpu_rdy_n  <= (state_d == ARB_AUX) || (state_d == ARB_DRAIN);
            aux_rvalid <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_huc_mem_arbiter.sv
module tb_huc_mem_arbiter;
    localparam int MAXB = 4;
    localparam int SLOT = 2;

    logic        clk = 1'b0;
    logic        reset_n, clk_en;
    logic [20:0] cpu_addr, aux_addr, mem_addr;
    logic        cpu_re, cpu_we, aux_req, aux_we;
    logic [7:0]  cpu_wdata, cpu_rdata, aux_wdata, aux_rdata, mem_wdata, mem_rdata;
    logic        cpu_rdy_n, aux_gnt, aux_rvalid, mem_re, mem_we;

    huc_mem_arbiter #(.AUX_MAX_BURST(MAXB), .CPU_MIN_SLOT(SLOT)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
        .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy_n(cpu_rdy_n),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_we(aux_we),
        .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata),
        .aux_rvalid(aux_rvalid), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: 256 bytes aliased on addr[7:0], one-cycle read latency.
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    bit         init_mem = 1'b1;

    function automatic logic [7:0] init_val(int i);
        return (i == 8'h40) ? 8'h3C : 8'((i * 7 + 3) & 255);
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    int         checks = 0, failures = 0;
    logic [7:0] rdq [$];
    logic [7:0] exp_rd;
    bit         mon_en = 1'b0;

    // Reference: who owns the bus (0 cpu, 1 aux, 2 drain), grants taken in
    // this burst, CPU cycles still owed before aux may win, pending rvalid.
    int m_owner = 0, m_cnt = 0, m_cool = 0;
    bit m_rv = 1'b0;
    bit force_en = 1'b0;
    int gcount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rvalid must match the oldest predicted read.
    always @(negedge clk) begin
        if (mon_en && aux_rvalid) begin
            if (rdq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL aux_rvalid_spurious: got rvalid data %0h expected no pending read", aux_rdata);
            end else begin
                exp_rd = rdq.pop_front();
                chk("aux_rdata", aux_rdata, exp_rd);
            end
        end
    end

    task automatic step(input bit en_chk);
        bit g, rd;
        @(negedge clk);
        g = (m_owner == 1) && clk_en && aux_req;
        if (aux_gnt) gcount++;
        if (en_chk) begin
            chk("cpu_rdy_n", cpu_rdy_n, m_owner != 0);
            chk("aux_gnt", aux_gnt, g);
            chk("aux_rvalid", aux_rvalid, m_rv);
            chk("mem_re", mem_re, (m_owner == 0) ? cpu_re : (g && !aux_we));
            chk("mem_we", mem_we, (m_owner == 0) ? cpu_we : (g && aux_we));
            if (m_owner == 0) chk("mem_addr_cpu", mem_addr, cpu_addr);
            if (g) chk("mem_addr_aux", mem_addr, aux_addr);
            if (g && aux_we) chk("mem_wdata_aux", mem_wdata, aux_wdata);
        end
        rd = g && !aux_we;
        if (rd && reset_n) rdq.push_back(shadow[aux_addr[7:0]]);
        if (m_owner == 0 && cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
        if (g && aux_we) shadow[aux_addr[7:0]] = aux_wdata;
        force_en = rd;
        if (!reset_n) begin
            m_owner = 0; m_cnt = 0; m_cool = 0; m_rv = 1'b0;
        end else if (clk_en) begin
            m_rv = rd;
            case (m_owner)
                0: if (m_cool > 0) m_cool--; else if (aux_req) m_owner = 1;
                1: if (g) begin
                       m_cnt++;
                       if (m_cnt == MAXB) begin m_owner = 2; m_cool = SLOT; end
                   end else if (!aux_req) m_owner = 2;
                default: begin m_owner = 0; m_cnt = 0; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic aux_set(input bit req, input bit we, input logic [20:0] a, input logic [7:0] d);
        aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        reset_n = 1'b0; clk_en = 1'b1;
        cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        aux_set(1'b0, 1'b0, '0, '0);
        #1;
        step(1'b0);
        init_mem = 1'b0;
        step(1'b0);
        reset_n = 1'b1;
        mon_en = 1'b1;

        // Reset state and a plain CPU read.
        step(1'b1);
        cpu_re = 1'b1; cpu_addr = 21'h000020;
        step(1'b1);
        cpu_re = 1'b0;

        // Two aux writes.
        aux_set(1'b1, 1'b1, 21'h1F0000, 8'hA5); step(1'b1);
        step(1'b1);
        aux_set(1'b1, 1'b1, 21'h1F0001, 8'h5A); step(1'b1);
        aux_set(1'b0, 1'b0, 21'h1F0001, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("mem_1F0000", mem[8'h00], 8'hA5);
        chk("mem_1F0001", mem[8'h01], 8'h5A);

        // Aux read of the preloaded 3C location.
        aux_set(1'b1, 1'b0, 21'h000040, 8'h00); step(1'b1);
        step(1'b1);
        aux_set(1'b0, 1'b0, 21'h000040, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1);

        // Continuous request: 4 grants, drain, hold, then re-grant.
        gcount = 0;
        aux_set(1'b1, 1'b1, 21'h1F0010, 8'h11);
        for (int i = 0; i < 9; i++) begin aux_wdata = 8'(8'h11 + i); step(1'b1); end
        chk("burst_limit_grants", gcount, 4);
        step(1'b1);
        chk("regrant_after_hold", gcount, 5);
        aux_set(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) step(1'b1);

        // clk_en frozen for 3 cycles mid-burst.
        gcount = 0;
        aux_set(1'b1, 1'b1, 21'h1F0020, 8'h77);
        for (int i = 0; i < 9; i++) begin
            clk_en = !(i >= 3 && i <= 5);
            step(1'b1);
        end
        clk_en = 1'b1;
        chk("frozen_burst_grants", gcount, 4);
        aux_set(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) step(1'b1);

        // Reset during a granted aux read.
        aux_set(1'b1, 1'b0, 21'h000040, 8'h00); step(1'b1);
        reset_n = 1'b0; step(1'b1);
        reset_n = 1'b1; aux_set(1'b0, 1'b0, '0, '0);
        step(1'b1);
        step(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            clk_en    = force_en ? 1'b1 : ($urandom_range(0, 5) != 0);
            reset_n   = ($urandom_range(0, 199) != 0);
            cpu_re    = $urandom_range(0, 1);
            cpu_we    = ($urandom_range(0, 3) == 0);
            cpu_addr  = 21'($urandom_range(0, 255));
            cpu_wdata = 8'($urandom);
            aux_set($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    21'(32'h1F0000 | $urandom_range(0, 255)), 8'($urandom));
            step(1'b1);
        end

        clk_en = 1'b1; reset_n = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0;
        aux_set(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("read_queue_empty", rdq.size(), 0);
        for (int i = 0; i < 256; i++) chk("mem_content", mem[i], shadow[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
